// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the systolic array edge logic
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_CAPTURE,
        W_SHIFT,
        STREAM,
        FLUSH
    } feeder_state_t;

    // Per-hop PE latency, also used by the PE and drain logic.
    localparam int DEFAULT_HOP_LATENCY = 4;

endpackage

// File: rtl/VX_shift_register.sv
// rtl/VX_shift_register.sv - fixed-depth delay line; the low RESETW bits are cleared by reset
module VX_shift_register #(
    parameter int DATAW  = 1,
    parameter int RESETW = 0,
    parameter int DEPTH  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out
);

    generate
        if (RESETW > 0) begin : g_rst
            logic [RESETW-1:0] stages [DEPTH];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < DEPTH; s++) stages[s] <= '0;
                end else if (enable) begin
                    stages[0] <= data_in[RESETW-1:0];
                    for (int s = 1; s < DEPTH; s++) stages[s] <= stages[s-1];
                end
            end

            assign data_out[RESETW-1:0] = stages[DEPTH-1];
        end

        if (RESETW < DATAW) begin : g_norst
            logic [DATAW-RESETW-1:0] stages [DEPTH];

            always_ff @(posedge clk) begin
                if (enable) begin
                    stages[0] <= data_in[DATAW-1:RESETW];
                    for (int s = 1; s < DEPTH; s++) stages[s] <= stages[s-1];
                end
            end

            assign data_out[DATAW-1:RESETW] = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - loads weights down the array columns, then streams skewed activations into the rows
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int HOP_LATENCY = DEFAULT_HOP_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [COLS*DATA_SIZE-1:0] w_data,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ROWS*DATA_SIZE-1:0] a_data,
    input  logic                      a_last,
    output logic [ROWS*DATA_SIZE-1:0] arr_in_data,
    output logic [COLS*DATA_SIZE-1:0] arr_in_sum,
    output logic                      arr_ld_weight,
    output logic                      arr_enable,
    output logic                      issue_valid,
    output logic                      issue_last,
    output logic                      busy
);

    localparam int WROW_W    = COLS * DATA_SIZE;
    localparam int AVEC_W    = ROWS * DATA_SIZE;
    localparam int CNT_W     = $clog2(ROWS) + 1;
    localparam int FLUSH_CYC = (ROWS - 1) * HOP_LATENCY;
    localparam int FL_W      = $clog2(FLUSH_CYC) + 1;
    localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

    feeder_state_t     state, state_next;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  scnt;
    logic [FL_W-1:0]   fcnt;
    logic              weights_loaded;
    logic [WROW_W-1:0] wbuf [ROWS];
    logic              w_acc, a_acc;
    logic [IDX_W-1:0]  rd_idx;
    logic [AVEC_W-1:0] skew_in, row_tap;

    assign w_ready = (state == W_CAPTURE);
    assign a_ready = (state == STREAM);
    assign w_acc   = w_valid && w_ready;
    assign a_acc   = a_valid && a_ready;
    assign rd_idx  = IDX_W'(CNT_W'(ROWS - 1) - scnt);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (w_valid)                         state_next = W_CAPTURE;
                else if (a_valid && weights_loaded)  state_next = STREAM;
            end
            W_CAPTURE: if (w_acc && wcnt == CNT_W'(ROWS - 1)) state_next = W_SHIFT;
            W_SHIFT:   if (scnt == CNT_W'(ROWS))              state_next = IDLE;
            STREAM:    if (a_acc && a_last) state_next = (FLUSH_CYC == 0) ? IDLE : FLUSH;
            FLUSH:     if (fcnt == FL_W'(FLUSH_CYC))          state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            arr_enable     <= 1'b0;
            wcnt           <= '0;
            scnt           <= CNT_W'(1);
            fcnt           <= FL_W'(1);
            weights_loaded <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            arr_enable <= 1'b1;
            if (state == IDLE)  wcnt <= '0;
            else if (w_acc)     wcnt <= wcnt + CNT_W'(1);
            scnt <= (state == W_SHIFT) ? scnt + CNT_W'(1) : CNT_W'(1);
            fcnt <= (state == FLUSH)   ? fcnt + FL_W'(1)  : FL_W'(1);
            if (state == IDLE && state_next == W_CAPTURE)   weights_loaded <= 1'b0;
            else if (state == W_SHIFT && state_next == IDLE) weights_loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) wbuf[r] <= '0;
        end else if (w_acc) begin
            wbuf[IDX_W'(wcnt)] <= w_data;
        end
    end

    // The bottom weight row goes out first; it is still arriving on w_data in the capture cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arr_ld_weight <= 1'b0;
            arr_in_sum    <= '0;
        end else if (state == W_CAPTURE && state_next == W_SHIFT) begin
            arr_ld_weight <= 1'b1;
            arr_in_sum    <= w_data;
        end else if (state == W_SHIFT && scnt != CNT_W'(ROWS)) begin
            arr_ld_weight <= 1'b1;
            arr_in_sum    <= wbuf[rd_idx];
        end else begin
            arr_ld_weight <= 1'b0;
            arr_in_sum    <= '0;
        end
    end

    assign skew_in = a_acc ? a_data : '0;
    assign row_tap[0 +: DATA_SIZE] = skew_in[0 +: DATA_SIZE];

    generate
        for (genvar i = 1; i < ROWS; i++) begin : g_skew
            VX_shift_register #(
                .DATAW  (DATA_SIZE),
                .RESETW (DATA_SIZE),
                .DEPTH  (i * HOP_LATENCY)
            ) u_skew (
                .clk      (clk),
                .reset_n  (reset_n),
                .enable   (1'b1),
                .data_in  (skew_in[i*DATA_SIZE +: DATA_SIZE]),
                .data_out (row_tap[i*DATA_SIZE +: DATA_SIZE])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arr_in_data <= '0;
            issue_valid <= 1'b0;
            issue_last  <= 1'b0;
        end else begin
            arr_in_data <= row_tap;
            issue_valid <= a_acc;
            issue_last  <= a_acc && a_last;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed/random bench for systolic_feeder against an event-timeline model
module tb_systolic_feeder;

    localparam int DW   = 32;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int HOP  = 4;
    localparam int VW   = 128;
    localparam int HIST = 4096;
    localparam int M_IDLE = 0, M_CAP = 1, M_SHIFT = 2, M_STR = 3, M_FLUSH = 4;

    logic                 clk, reset_n;
    logic                 w_valid, w_ready;
    logic [COLS*DW-1:0]   w_data;
    logic                 a_valid, a_ready, a_last;
    logic [ROWS*DW-1:0]   a_data;
    logic [ROWS*DW-1:0]   arr_in_data;
    logic [COLS*DW-1:0]   arr_in_sum;
    logic                 arr_ld_weight, arr_enable, issue_valid, issue_last, busy;

    systolic_feeder #(.DATA_SIZE(DW), .ROWS(ROWS), .COLS(COLS), .HOP_LATENCY(HOP)) dut (
        .clk(clk), .reset_n(reset_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .arr_in_data(arr_in_data), .arr_in_sum(arr_in_sum),
        .arr_ld_weight(arr_ld_weight), .arr_enable(arr_enable),
        .issue_valid(issue_valid), .issue_last(issue_last), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;
    int m_mode, m_cnt, t_last;
    bit m_loaded, last_wacc, last_aacc;
    logic [ROWS*DW-1:0] hist [HIST];
    logic [COLS*DW-1:0] wrows [ROWS];
    logic [ROWS*DW-1:0] e_data;
    logic [COLS*DW-1:0] e_sum;
    logic e_ld, e_en, e_iv, e_il, e_busy, e_wr, e_ar;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_loaded = 0; t_last = -100;
        last_wacc = 0; last_aacc = 0;
        for (int k = 0; k < HIST; k++) hist[k] = '0;
        e_data = '0; e_sum = '0; e_ld = 0; e_en = 0; e_iv = 0; e_il = 0;
        e_busy = 0; e_wr = 0; e_ar = 0;
    endtask

    // Advance the spec-level model by one rising edge using the inputs held across it.
    task automatic model_edge();
        bit wacc, aacc;
        int idx;
        logic [ROWS*DW-1:0] v;
        wacc = (m_mode == M_CAP) && w_valid;
        aacc = (m_mode == M_STR) && a_valid;
        hist[n] = aacc ? a_data : '0;
        case (m_mode)
            M_IDLE: begin
                if (w_valid) begin m_mode = M_CAP; m_cnt = 0; m_loaded = 0; end
                else if (a_valid && m_loaded) m_mode = M_STR;
            end
            M_CAP: if (wacc) begin
                wrows[m_cnt] = w_data;
                m_cnt++;
                if (m_cnt == ROWS) begin m_mode = M_SHIFT; m_cnt = 0; t_last = n; end
            end
            M_SHIFT: begin
                m_cnt++;
                if (m_cnt == ROWS) begin m_mode = M_IDLE; m_loaded = 1; end
            end
            M_STR: if (aacc && a_last) begin m_mode = M_FLUSH; m_cnt = 0; end
            default: begin
                m_cnt++;
                if (m_cnt == (ROWS - 1) * HOP) m_mode = M_IDLE;
            end
        endcase
        last_wacc = wacc;
        last_aacc = aacc;
        for (int i = 0; i < ROWS; i++) begin
            idx = n - i * HOP;
            v = (idx >= 0) ? hist[idx] : '0;
            e_data[i*DW +: DW] = v[i*DW +: DW];
        end
        e_ld = (n >= t_last) && (n < t_last + ROWS);
        e_sum = e_ld ? wrows[ROWS-1-(n-t_last)] : '0;
        e_en = 1;
        e_iv = aacc;
        e_il = aacc && a_last;
        e_busy = (m_mode != M_IDLE);
        e_wr = (m_mode == M_CAP);
        e_ar = (m_mode == M_STR);
    endtask

    task automatic check_all();
        chk("arr_in_data", arr_in_data, e_data);
        chk("arr_in_sum", arr_in_sum, e_sum);
        chk("arr_ld_weight", arr_ld_weight, e_ld);
        chk("arr_enable", arr_enable, e_en);
        chk("issue_valid", issue_valid, e_iv);
        chk("issue_last", issue_last, e_il);
        chk("busy", busy, e_busy);
        chk("w_ready", w_ready, e_wr);
        chk("a_ready", a_ready, e_ar);
    endtask

    task automatic step();
        n++;
        @(posedge clk);
        if (reset_n) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic send_w(input logic [COLS*DW-1:0] d);
        w_valid = 1; w_data = d;
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_wacc) break;
        end
        chk("w_beat_taken", last_wacc, 1'b1);
        w_valid = 0;
    endtask

    task automatic send_a(input logic [ROWS*DW-1:0] d, input logic last);
        a_valid = 1; a_data = d; a_last = last;
        for (int k = 0; k < 40; k++) begin
            step();
            if (last_aacc) break;
        end
        chk("a_beat_taken", last_aacc, 1'b1);
        a_valid = 0; a_last = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            step();
            if (m_mode == M_IDLE) break;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    function automatic logic [VW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [ROWS*DW-1:0] vec;
        logic [COLS*DW-1:0] nw0;
        reset_n = 1; w_valid = 0; w_data = '0; a_valid = 0; a_data = '0; a_last = 0;
        model_reset();
        #2 reset_n = 0;
        repeat (3) step();

        // Release; activations must be ignored with no weights loaded.
        reset_n = 1;
        a_valid = 1; a_data = rnd();
        repeat (4) step();
        a_valid = 0;

        // Weight load with a one-cycle gap after the first beat.
        send_w(rnd());
        step();
        for (int r = 1; r < ROWS; r++) send_w(rnd());
        wait_idle();

        // Directed skew vector followed by idle slots.
        vec = {32'd40, 32'd30, 32'd20, 32'd10};
        send_a(vec, 1'b0);
        repeat (14) step();

        // A, bubble, B, then a random stream with random gaps ending in last.
        send_a(rnd(), 1'b0);
        step();
        send_a(rnd(), 1'b0);
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(2) == 0) step();
            send_a(rnd(), k == 9);
        end
        wait_idle();
        repeat (3) step();

        // Second stream on the same weights; a weight load requested mid-stream waits for idle.
        send_a(rnd(), 1'b0);
        nw0 = rnd();
        w_valid = 1; w_data = nw0;
        for (int k = 0; k < 4; k++) send_a(rnd(), k == 3);
        send_w(nw0);
        for (int r = 1; r < ROWS; r++) send_w(rnd());
        wait_idle();

        // Reset in the middle of a stream.
        send_a(rnd(), 1'b0);
        send_a(rnd(), 1'b0);
        reset_n = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        reset_n = 1;
        a_valid = 1; a_data = rnd();
        repeat (5) step();
        a_valid = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
